// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel enable, H/V counters, sync/blank,
// shifter load strobes, frame counter and frame-synchronous screen flip.
module video_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_TOTAL  = 320,
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned HS_START = 260,
    parameter int unsigned HS_END   = 288,
    parameter int unsigned V_TOTAL  = 262,
    parameter int unsigned V_ACTIVE = 224,
    parameter int unsigned VS_START = 230,
    parameter int unsigned VS_END   = 234,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned SHIFT_W  = 8,
    parameter int unsigned FRAME_W  = 6,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               RESET_n,
    input  logic               flip,
    output logic               pxl_cen,
    output logic [HW-1:0]      hcnt,
    output logic [VW-1:0]      vcnt,
    output logic [HW-1:0]      scr_h,
    output logic [VW-1:0]      scr_v,
    output logic               flip_q,
    output logic               hsync,
    output logic               vsync,
    output logic               hblank,
    output logic               vblank,
    output logic               load,
    output logic               vb_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               sparkle
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] LOAD_MASK = HW'(SHIFT_W - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("video_timing_gen: CLK_DIV must be at least 1");
    end
    if (!(H_ACTIVE < HS_START && HS_START < HS_END && HS_END <= H_TOTAL)) begin : g_bad_h
        $error("video_timing_gen: illegal horizontal timing");
    end
    if (!(V_ACTIVE <= VS_START && VS_START < VS_END && VS_END <= V_TOTAL)) begin : g_bad_v
        $error("video_timing_gen: illegal vertical timing");
    end
    if (SHIFT_W == 0 || (SHIFT_W & (SHIFT_W - 1)) != 0) begin : g_bad_shift
        $error("video_timing_gen: SHIFT_W must be a power of 2");
    end

    logic [DW-1:0]      div_q, div_d;
    logic               pxl_cen_q, pxl_cen_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [VW-1:0]      vcnt_q, vcnt_d;
    logic [HW-1:0]      scr_h_q, scr_h_d;
    logic [VW-1:0]      scr_v_q, scr_v_d;
    logic               flip_frame_q, flip_frame_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               hblank_q, hblank_d;
    logic               vblank_q, vblank_d;
    logic               load_q, load_d;
    logic               vb_start_q, vb_start_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic h_last_c;
    logic v_last_c;
    logic hs_act_c;
    logic vs_act_c;

    // Next-state for counters, then decodes computed from the next count so
    // every registered output lines up with the count it describes.
    always_comb begin
        div_d        = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        pxl_cen_d    = (div_d == DIV_LAST);
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        flip_frame_d = flip_frame_q;
        frame_d      = frame_q;
        vb_start_d   = 1'b0;
        h_last_c     = (hcnt_q == HW'(H_TOTAL - 1));
        v_last_c     = (vcnt_q == VW'(V_TOTAL - 1));

        if (pxl_cen_q) begin
            if (h_last_c) begin
                hcnt_d = '0;
                if (v_last_c) begin
                    vcnt_d       = '0;
                    flip_frame_d = flip;
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                end
                vb_start_d = (vcnt_d == VW'(V_ACTIVE));
            end else begin
                hcnt_d = hcnt_q + HW'(1);
            end
        end
        if (vb_start_d) begin
            frame_d = frame_q + FRAME_W'(1);
        end

        hblank_d = (hcnt_d >= HW'(H_ACTIVE));
        vblank_d = (vcnt_d >= VW'(V_ACTIVE));
        hs_act_c = (hcnt_d >= HW'(HS_START)) && ({1'b0, hcnt_d} < (HW + 1)'(HS_END));
        vs_act_c = (vcnt_d >= VW'(VS_START)) && ({1'b0, vcnt_d} < (VW + 1)'(VS_END));
        hsync_d  = HS_POL ? hs_act_c : ~hs_act_c;
        vsync_d  = VS_POL ? vs_act_c : ~vs_act_c;
        load_d   = pxl_cen_d && ((hcnt_d & LOAD_MASK) == LOAD_MASK);

        // Mirroring applies to visible pixels only; blanking passes raw counts.
        if (flip_frame_d && !hblank_d && !vblank_d) begin
            scr_h_d = HW'(H_ACTIVE - 1) - hcnt_d;
            scr_v_d = VW'(V_ACTIVE - 1) - vcnt_d;
        end else begin
            scr_h_d = hcnt_d;
            scr_v_d = vcnt_d;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            div_q        <= '0;
            pxl_cen_q    <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            scr_h_q      <= '0;
            scr_v_q      <= '0;
            flip_frame_q <= 1'b0;
            hsync_q      <= ~HS_POL;
            vsync_q      <= ~VS_POL;
            hblank_q     <= 1'b0;
            vblank_q     <= 1'b0;
            load_q       <= 1'b0;
            vb_start_q   <= 1'b0;
            frame_q      <= '0;
        end else begin
            div_q        <= div_d;
            pxl_cen_q    <= pxl_cen_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            scr_h_q      <= scr_h_d;
            scr_v_q      <= scr_v_d;
            flip_frame_q <= flip_frame_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            hblank_q     <= hblank_d;
            vblank_q     <= vblank_d;
            load_q       <= load_d;
            vb_start_q   <= vb_start_d;
            frame_q      <= frame_d;
        end
    end

    assign pxl_cen   = pxl_cen_q;
    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign scr_h     = scr_h_q;
    assign scr_v     = scr_v_q;
    assign flip_q    = flip_frame_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign hblank    = hblank_q;
    assign vblank    = vblank_q;
    assign load      = load_q;
    assign vb_start  = vb_start_q;
    assign frame_cnt = frame_q;
    assign sparkle   = frame_q[FRAME_W-1];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: three generator instances (defaults, a small raster for
// frame-level behaviour, CLK_DIV=1 for async reset); monitors pop expectations.
module tb_video_timing_gen;

    localparam int N_K = 26;
    localparam int K_RST_A = 0, K_RST_B = 1, K_RST_C = 2, K_CEN_C = 3;
    localparam int K_HSR = 4, K_HSF = 5, K_HSW = 6, K_HBR = 7, K_HBF = 8, K_LINE = 9;
    localparam int K_LOADN = 10, K_LOADBAD = 11, K_CENN = 12, K_CENBAD = 13, K_SEQ = 14;
    localparam int K_PROBE = 15, K_VBPOS = 16, K_FCNT = 17, K_VBW = 18, K_SPK = 19;
    localparam int K_VSR = 20, K_VSF = 21, K_VSW = 22, K_VBR = 23, K_VBF = 24, K_HSB = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic flip_a = 1'b0, flip_b = 1'b0, flip_c = 1'b0;

    int sb[N_K][$];
    int n_checks = 0;
    int n_fail = 0;

    // Instance A: default parameters
    logic       pxl_cen_a, flip_q_a, hsync_a, vsync_a, hblank_a, vblank_a, load_a, vb_start_a, sparkle_a;
    logic [8:0] hcnt_a, vcnt_a, scr_h_a, scr_v_a;
    logic [5:0] frame_a;

    video_timing_gen dut_a (
        .clk(clk), .RESET_n(rst_a), .flip(flip_a), .pxl_cen(pxl_cen_a),
        .hcnt(hcnt_a), .vcnt(vcnt_a), .scr_h(scr_h_a), .scr_v(scr_v_a),
        .flip_q(flip_q_a), .hsync(hsync_a), .vsync(vsync_a), .hblank(hblank_a),
        .vblank(vblank_a), .load(load_a), .vb_start(vb_start_a),
        .frame_cnt(frame_a), .sparkle(sparkle_a)
    );

    // Instance B: small raster, active-low syncs
    logic       pxl_cen_b, flip_q_b, hsync_b, vsync_b, hblank_b, vblank_b, load_b, vb_start_b, sparkle_b;
    logic [5:0] hcnt_b, scr_h_b;
    logic [3:0] vcnt_b, scr_v_b;
    logic [5:0] frame_b;

    video_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(40), .H_ACTIVE(32), .HS_START(34), .HS_END(38),
        .V_TOTAL(10), .V_ACTIVE(8), .VS_START(8), .VS_END(10),
        .HS_POL(1'b0), .VS_POL(1'b0), .SHIFT_W(8), .FRAME_W(6)
    ) dut_b (
        .clk(clk), .RESET_n(rst_b), .flip(flip_b), .pxl_cen(pxl_cen_b),
        .hcnt(hcnt_b), .vcnt(vcnt_b), .scr_h(scr_h_b), .scr_v(scr_v_b),
        .flip_q(flip_q_b), .hsync(hsync_b), .vsync(vsync_b), .hblank(hblank_b),
        .vblank(vblank_b), .load(load_b), .vb_start(vb_start_b),
        .frame_cnt(frame_b), .sparkle(sparkle_b)
    );

    // Instance C: CLK_DIV=1
    logic       pxl_cen_c, flip_q_c, hsync_c, vsync_c, hblank_c, vblank_c, load_c, vb_start_c, sparkle_c;
    logic [8:0] hcnt_c, vcnt_c, scr_h_c, scr_v_c;
    logic [5:0] frame_c;

    video_timing_gen #(.CLK_DIV(1)) dut_c (
        .clk(clk), .RESET_n(rst_c), .flip(flip_c), .pxl_cen(pxl_cen_c),
        .hcnt(hcnt_c), .vcnt(vcnt_c), .scr_h(scr_h_c), .scr_v(scr_v_c),
        .flip_q(flip_q_c), .hsync(hsync_c), .vsync(vsync_c), .hblank(hblank_c),
        .vblank(vblank_c), .load(load_c), .vb_start(vb_start_c),
        .frame_cnt(frame_c), .sparkle(sparkle_c)
    );

    function automatic string kname(input int k);
        case (k)
            K_RST_A:   return "reset_a";
            K_RST_B:   return "reset_b";
            K_RST_C:   return "reset_c";
            K_CEN_C:   return "cen_const_c";
            K_HSR:     return "hsync_start_hcnt";
            K_HSF:     return "hsync_end_hcnt";
            K_HSW:     return "hsync_width_clk";
            K_HBR:     return "hblank_start_hcnt";
            K_HBF:     return "hblank_end_hcnt";
            K_LINE:    return "line_len_clk";
            K_LOADN:   return "loads_per_line";
            K_LOADBAD: return "load_misplaced";
            K_CENN:    return "cen_per_line";
            K_CENBAD:  return "cen_period_err";
            K_SEQ:     return "hcnt_seq_err";
            K_PROBE:   return "flip_probe";
            K_VBPOS:   return "vb_start_pos";
            K_FCNT:    return "frame_cnt";
            K_VBW:     return "vb_start_width";
            K_SPK:     return "sparkle_toggle_frame";
            K_VSR:     return "vsync_start_pos";
            K_VSF:     return "vsync_end_pos";
            K_VSW:     return "vsync_width_clk";
            K_VBR:     return "vblank_start_pos";
            K_VBF:     return "vblank_end_pos";
            K_HSB:     return "hsync_b_start_hcnt";
            default:   return "unknown";
        endcase
    endfunction

    task automatic check(input int k, input int got);
        int exp_v;
        if (sb[k].size() == 0) return;
        exp_v = sb[k].pop_front();
        n_checks++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", kname(k), got, exp_v);
        end
    endtask

    task automatic timeout(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: condition not reached, expected within bound", what);
    endtask

    function automatic int pack_st(input int h, input int v, input int f, input logic [7:0] fl);
        return (h << 23) | (v << 14) | (f << 8) | 32'(fl);
    endfunction

    // Reset monitors: sample between edges just after RESET_n falls
    always @(negedge rst_a) begin
        #1;
        check(K_RST_A, pack_st(32'(hcnt_a), 32'(vcnt_a), 32'(frame_a),
              {pxl_cen_a, load_a, vb_start_a, hblank_a, vblank_a, hsync_a, vsync_a, flip_q_a}));
    end
    always @(negedge rst_b) begin
        #1;
        check(K_RST_B, pack_st(32'(hcnt_b), 32'(vcnt_b), 32'(frame_b),
              {pxl_cen_b, load_b, vb_start_b, hblank_b, vblank_b, hsync_b, vsync_b, flip_q_b}));
    end

    int cyc_c = 0, cen_bad_c = 0;
    always @(negedge rst_c) begin
        #1;
        check(K_RST_C, pack_st(32'(hcnt_c), 32'(vcnt_c), 32'(frame_c),
              {pxl_cen_c, load_c, vb_start_c, hblank_c, vblank_c, hsync_c, vsync_c, flip_q_c}));
        check(K_CEN_C, cen_bad_c);
        cen_bad_c = 0;
        cyc_c = 0;
    end
    always @(negedge clk) begin
        if (rst_c) begin
            if (cyc_c >= 1 && !pxl_cen_c) cen_bad_c++;
            cyc_c++;
        end
    end

    // Monitor A: horizontal timing measured per line
    int ta, wrap_t, hs_t, last_cen, cen_n, cen_bad, load_n, load_bad, seq_err;
    bit have_wrap;
    logic [8:0] ph_a;
    logic phs_a, phb_a;
    always @(negedge clk) begin
        if (!rst_a) begin
            ta = 0; wrap_t = 0; hs_t = 0; last_cen = -1; have_wrap = 0;
            cen_n = 0; cen_bad = 0; load_n = 0; load_bad = 0; seq_err = 0;
            ph_a = '0; phs_a = 1'b0; phb_a = 1'b0;
        end else begin
            ta++;
            if (pxl_cen_a) begin
                cen_n++;
                if (last_cen >= 0 && ta - last_cen != 2) cen_bad++;
                last_cen = ta;
            end
            if (load_a) begin
                load_n++;
                if (!pxl_cen_a || hcnt_a[2:0] != 3'd7) load_bad++;
            end
            if (hcnt_a != ph_a) begin
                if (32'(hcnt_a) != (32'(ph_a) + 1) % 320) seq_err++;
                if (hcnt_a == 9'd0) begin
                    if (have_wrap) check(K_LINE, ta - wrap_t);
                    check(K_LOADN, load_n);
                    check(K_LOADBAD, load_bad);
                    check(K_CENN, cen_n);
                    check(K_CENBAD, cen_bad);
                    check(K_SEQ, seq_err);
                    load_n = 0; load_bad = 0; cen_n = 0; cen_bad = 0; seq_err = 0;
                    wrap_t = ta;
                    have_wrap = 1;
                end
            end
            if (hsync_a && !phs_a) begin check(K_HSR, 32'(hcnt_a)); hs_t = ta; end
            if (!hsync_a && phs_a) begin check(K_HSF, 32'(hcnt_a)); check(K_HSW, ta - hs_t); end
            if (hblank_a && !phb_a) check(K_HBR, 32'(hcnt_a));
            if (!hblank_a && phb_a) check(K_HBF, 32'(hcnt_a));
            ph_a = hcnt_a; phs_a = hsync_a; phb_a = hblank_a;
        end
    end

    // Monitor B: vertical timing, frame counter, flip probes
    int tb_t, vb_t, vs_t, frame_idx_b, vb_n_b;
    logic [5:0] ph_b;
    logic pvb, psp, pvs, pvbl, phs_b;
    always @(negedge clk) begin
        if (!rst_b) begin
            tb_t = 0; vb_t = 0; vs_t = 0; frame_idx_b = 0; vb_n_b = 0;
            ph_b = '0; pvb = 1'b0; psp = 1'b0; pvs = 1'b0; pvbl = 1'b0; phs_b = 1'b0;
        end else begin
            tb_t++;
            if (hcnt_b != ph_b) begin
                if (hcnt_b == 6'd0 && vcnt_b == 4'd0) frame_idx_b++;
                if (frame_idx_b >= 1 && frame_idx_b <= 6 &&
                    ((hcnt_b == 6'd0 && vcnt_b == 4'd0) || (hcnt_b == 6'd35 && vcnt_b == 4'd2) ||
                     (hcnt_b == 6'd5 && vcnt_b == 4'd5)))
                    check(K_PROBE, 32'(scr_h_b) * 1024 + 32'(scr_v_b) * 2 + 32'(flip_q_b));
            end
            if (vb_start_b) begin
                vb_n_b++;
                check(K_VBPOS, 32'(hcnt_b) * 256 + 32'(vcnt_b));
                check(K_FCNT, 32'(frame_b));
                vb_t = tb_t;
            end
            if (!vb_start_b && pvb) check(K_VBW, tb_t - vb_t);
            if (sparkle_b != psp) check(K_SPK, vb_n_b);
            if (!vsync_b && pvs == 1'b0 && tb_t > 1 && vs_t >= 0) begin end
            if (~vsync_b && !pvs) begin check(K_VSR, 32'(hcnt_b) * 256 + 32'(vcnt_b)); vs_t = tb_t; end
            if (vsync_b && pvs) begin
                check(K_VSF, 32'(hcnt_b) * 256 + 32'(vcnt_b));
                check(K_VSW, tb_t - vs_t);
            end
            if (vblank_b && !pvbl) check(K_VBR, 32'(hcnt_b) * 256 + 32'(vcnt_b));
            if (!vblank_b && pvbl) check(K_VBF, 32'(hcnt_b) * 256 + 32'(vcnt_b));
            if (~hsync_b && !phs_b) check(K_HSB, 32'(hcnt_b));
            ph_b = hcnt_b; pvb = vb_start_b; psp = sparkle_b; pvs = ~vsync_b;
            pvbl = vblank_b; phs_b = ~hsync_b;
        end
    end

    initial begin
        int fl;
        // Reset expectations: all counters/flags zero; B's syncs idle high
        sb[K_RST_A].push_back(0);
        sb[K_RST_B].push_back(pack_st(0, 0, 0, 8'b0000_0110));
        sb[K_RST_C].push_back(0);
        for (int i = 0; i < 3; i++) begin
            sb[K_HSR].push_back(260);   sb[K_HSF].push_back(288);  sb[K_HSW].push_back(56);
            sb[K_HBR].push_back(256);   sb[K_HBF].push_back(0);
            sb[K_LOADN].push_back(40);  sb[K_LOADBAD].push_back(0);
            sb[K_CENN].push_back(320);  sb[K_CENBAD].push_back(0);  sb[K_SEQ].push_back(0);
            sb[K_VSR].push_back(8);     sb[K_VSF].push_back(0);    sb[K_VSW].push_back(160);
            sb[K_VBR].push_back(8);     sb[K_VBF].push_back(0);    sb[K_VBW].push_back(1);
        end
        for (int i = 0; i < 2; i++) begin
            sb[K_LINE].push_back(640);
            sb[K_HSB].push_back(34);
        end
        for (int k = 1; k <= 66; k++) begin
            sb[K_VBPOS].push_back(8);
            sb[K_FCNT].push_back(k % 64);
        end
        sb[K_SPK].push_back(32);
        sb[K_SPK].push_back(64);
        // Flip raised in frame 2, dropped in frame 4: frames 3 and 4 mirrored
        for (int k = 1; k <= 6; k++) begin
            fl = (k == 3 || k == 4) ? 1 : 0;
            sb[K_PROBE].push_back(fl ? (31 * 1024 + 7 * 2 + 1) : 0);
            sb[K_PROBE].push_back(35 * 1024 + 2 * 2 + fl);
            sb[K_PROBE].push_back(fl ? (26 * 1024 + 2 * 2 + 1) : (5 * 1024 + 5 * 2));
        end

        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // Async reset on C in the active region, then inside hsync
        for (int i = 0; i < 2000 && hcnt_c != 9'd150; i++) @(negedge clk);
        if (hcnt_c != 9'd150) timeout("c_hcnt150");
        #2;
        sb[K_RST_C].push_back(0);
        sb[K_CEN_C].push_back(0);
        rst_c = 1'b0;
        @(negedge clk);
        #2;
        rst_c = 1'b1;
        for (int i = 0; i < 2000 && hcnt_c != 9'd270; i++) @(negedge clk);
        if (hcnt_c != 9'd270) timeout("c_hcnt270");
        #2;
        sb[K_RST_C].push_back(0);
        sb[K_CEN_C].push_back(0);
        rst_c = 1'b0;
        @(negedge clk);
        #2;
        rst_c = 1'b1;

        for (int i = 0; i < 5000 && !(frame_idx_b == 2 && vcnt_b == 4'd3); i++) @(negedge clk);
        if (!(frame_idx_b == 2 && vcnt_b == 4'd3)) timeout("b_flip_on");
        #2 flip_b = 1'b1;
        for (int i = 0; i < 5000 && !(frame_idx_b == 4 && vcnt_b == 4'd3); i++) @(negedge clk);
        if (!(frame_idx_b == 4 && vcnt_b == 4'd3)) timeout("b_flip_off");
        #2 flip_b = 1'b0;

        for (int i = 0; i < 60000 && vb_n_b < 66; i++) @(negedge clk);
        if (vb_n_b < 66) timeout("b_frames");
        repeat (10) @(negedge clk);

        for (int k = 0; k < N_K; k++) begin
            n_checks++;
            if (sb[k].size() != 0) begin
                n_fail++;
                $display("FAIL missing_%s: got no event for %0d expected entries, required 0 left",
                         kname(k), sb[k].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
